// File: rtl/dma_ch_scheduler.sv
// Round-robin DMA channel scheduler: arbitrates channel requests, issues one
// transfer at a time to the DMA master and reports done / error per channel.
//
// state | meaning
// IDLE  | no transfer; waiting for any ch_req
// ARB   | pick round-robin winner, pulse grant, latch len/addr
// ISSUE | pulse dma_start, clear timeout counter
// WAIT  | wait for dma_done or timeout
module dma_ch_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_CH-1:0]      ch_req,
    input  logic [6*NUM_CH-1:0]    ch_len,
    input  logic [32*NUM_CH-1:0]   ch_addr,
    output logic [NUM_CH-1:0]      ch_gnt,
    output logic [NUM_CH-1:0]      ch_done,
    output logic [NUM_CH-1:0]      ch_err,
    output logic                   dma_start,
    output logic [5:0]             dma_len,
    output logic [31:0]            dma_addr,
    output logic                   dma_abort,
    input  logic                   dma_done,
    output logic                   busy
);

    localparam int IW = $clog2(NUM_CH);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARB, ISSUE, WAIT} state_t;

    state_t              state;
    logic [IW-1:0]       last_gnt;
    logic [IW-1:0]       cand;
    logic [IW-1:0]       win_idx;
    logic                win_vld;
    logic [NUM_CH-1:0]   win_oh;
    logic [NUM_CH-1:0]   act_oh;
    logic [5:0]          win_len;
    logic [31:0]         win_addr;
    logic [15:0]         to_cnt;

    // Search starts one past the last winner; the IW-bit add wraps naturally.
    always_comb begin
        cand    = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = last_gnt + IW'(i);
            if (!win_vld && ch_req[cand]) begin
                win_idx = cand;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        win_oh   = '0;
        win_len  = '0;
        win_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (IW'(i) == win_idx) begin
                win_oh[i] = 1'b1;
                win_len   = ch_len[6*i +: 6];
                win_addr  = ch_addr[32*i +: 32];
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= IDLE;
            last_gnt  <= IW'(NUM_CH - 1);
            to_cnt    <= '0;
            act_oh    <= '0;
            ch_gnt    <= '0;
            ch_done   <= '0;
            ch_err    <= '0;
            dma_start <= 1'b0;
            dma_abort <= 1'b0;
            dma_len   <= '0;
            dma_addr  <= '0;
        end else begin
            ch_gnt    <= '0;
            ch_done   <= '0;
            ch_err    <= '0;
            dma_start <= 1'b0;
            dma_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (|ch_req) state <= ARB;
                end
                ARB: begin
                    if (win_vld) begin
                        ch_gnt   <= win_oh;
                        act_oh   <= win_oh;
                        last_gnt <= win_idx;
                        dma_len  <= win_len;
                        dma_addr <= win_addr;
                        // A zero-length buffer is granted and rejected in one step.
                        if (win_len == 6'd0) begin
                            ch_err <= win_oh;
                            state  <= IDLE;
                        end else begin
                            state  <= ISSUE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    dma_start <= 1'b1;
                    to_cnt    <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (dma_done) begin
                        ch_done <= act_oh;
                        state   <= IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        dma_abort <= 1'b1;
                        ch_err    <= act_oh;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_ch_scheduler.sv
// Directed bench for dma_ch_scheduler with TIMEOUT=8.
module tb_dma_ch_scheduler;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic [3:0]   ch_req;
    logic [23:0]  ch_len;
    logic [127:0] ch_addr;
    logic [3:0]   ch_gnt, ch_done, ch_err;
    logic         dma_start, dma_abort, dma_done, busy;
    logic [5:0]   dma_len;
    logic [31:0]  dma_addr;

    int checks   = 0;
    int failures = 0;

    dma_ch_scheduler #(.NUM_CH(4), .TIMEOUT(8)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .ch_req(ch_req), .ch_len(ch_len),
        .ch_addr(ch_addr), .ch_gnt(ch_gnt), .ch_done(ch_done), .ch_err(ch_err),
        .dma_start(dma_start), .dma_len(dma_len), .dma_addr(dma_addr),
        .dma_abort(dma_abort), .dma_done(dma_done), .busy(busy)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_ch(input int n, input logic [5:0] len, input logic [31:0] addr);
        ch_len[6*n +: 6]   = len;
        ch_addr[32*n +: 32] = addr;
    endtask

    // Polls up to 10 cycles for a grant; returns 0 if none appeared.
    task automatic wait_gnt(output logic [3:0] g);
        g = 4'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ch_gnt != 4'b0) begin
                g = ch_gnt;
                break;
            end
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        tick(); tick();
        checks++; if ({ch_gnt, ch_done, ch_err} !== 12'h0) begin failures++; $display("FAIL reset_pulses got=%h exp=000", {ch_gnt, ch_done, ch_err}); end
        checks++; if ({dma_start, dma_abort, busy} !== 3'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {dma_start, dma_abort, busy}); end
        checks++; if ({dma_len, dma_addr} !== 38'h0) begin failures++; $display("FAIL reset_lenaddr got=%h exp=0", {dma_len, dma_addr}); end
        HRESET = 1'b0;
        tick();
    endtask

    task automatic test_single();
        set_ch(0, 6'd16, 32'h0000_0100);
        ch_req = 4'b0001;
        tick();
        checks++; if (ch_gnt !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL single_arb gnt=%b busy=%b exp gnt=0000 busy=1", ch_gnt, busy); end
        tick();
        checks++; if (ch_gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", ch_gnt); end
        ch_req = 4'b0000;
        tick();
        checks++; if (dma_start !== 1'b1 || ch_gnt !== 4'b0) begin failures++; $display("FAIL single_start start=%b gnt=%b exp start=1 gnt=0000", dma_start, ch_gnt); end
        checks++; if (dma_len !== 6'd16 || dma_addr !== 32'h100) begin failures++; $display("FAIL single_lenaddr len=%0d addr=%h exp len=16 addr=00000100", dma_len, dma_addr); end
        tick();
        checks++; if (dma_start !== 1'b0 || dma_len !== 6'd16) begin failures++; $display("FAIL single_start_1cyc start=%b len=%0d exp start=0 len=16", dma_start, dma_len); end
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        checks++; if (ch_done !== 4'b0001 || ch_err !== 4'b0) begin failures++; $display("FAIL single_done done=%b err=%b exp done=0001 err=0000", ch_done, ch_err); end
        tick();
        checks++; if (ch_done !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_idle done=%b busy=%b exp done=0000 busy=0", ch_done, busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] g;
        HRESET = 1'b1; tick(); HRESET = 1'b0;
        for (int n = 0; n < 4; n++) set_ch(n, 6'(n + 4), 32'h1000 * (n + 1));
        ch_req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(g);
            checks++; if (g !== 4'(1 << k)) begin failures++; $display("FAIL rr_order[%0d] got=%b exp=%b", k, g, 4'(1 << k)); end
            tick();
            checks++; if (dma_len !== 6'(k + 4)) begin failures++; $display("FAIL rr_len[%0d] got=%0d exp=%0d", k, dma_len, k + 4); end
            dma_done = 1'b1;
            tick();
            dma_done = 1'b0;
            if (k == 3) ch_req = 4'b0001;
        end
        wait_gnt(g);
        checks++; if (g !== 4'b0001) begin failures++; $display("FAIL rr_fifth got=%b exp=0001", g); end
        ch_req = 4'b0000;
        tick();
        dma_done = 1'b1; tick(); dma_done = 1'b0; tick();
    endtask

    task automatic test_req_drop();
        ch_req = 4'b0010;
        tick();
        ch_req = 4'b0000;
        tick();
        checks++; if (ch_gnt !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL req_drop gnt=%b busy=%b exp gnt=0000 busy=0", ch_gnt, busy); end
    endtask

    task automatic test_zero_len();
        set_ch(2, 6'd0, 32'hDEAD_0000);
        ch_req = 4'b0100;
        tick(); tick();
        checks++; if (ch_gnt !== 4'b0100 || ch_err !== 4'b0100) begin failures++; $display("FAIL zlen_gnt_err gnt=%b err=%b exp 0100/0100", ch_gnt, ch_err); end
        checks++; if (dma_start !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zlen_idle start=%b busy=%b exp 0/0", dma_start, busy); end
        ch_req = 4'b0000;
        tick();
        checks++; if ({ch_gnt, ch_err, dma_start} !== 9'b0) begin failures++; $display("FAIL zlen_after got=%b exp=0", {ch_gnt, ch_err, dma_start}); end
        set_ch(2, 6'd9, 32'h0000_2200);
    endtask

    task automatic test_timeout();
        logic [3:0] g;
        int abort_seen;
        ch_req = 4'b0010;
        wait_gnt(g);
        tick();
        ch_req = 4'b0000;
        checks++; if (dma_start !== 1'b1) begin failures++; $display("FAIL to_start got=%b exp=1", dma_start); end
        abort_seen = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (dma_abort !== 1'b0) abort_seen++;
        end
        checks++; if (abort_seen !== 0) begin failures++; $display("FAIL to_early_abort count=%0d exp=0", abort_seen); end
        tick();
        checks++; if (dma_abort !== 1'b1 || ch_err !== 4'b0010 || ch_done !== 4'b0) begin failures++; $display("FAIL to_abort abort=%b err=%b done=%b exp 1/0010/0000", dma_abort, ch_err, ch_done); end
        tick();
        checks++; if (dma_abort !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL to_after abort=%b busy=%b exp 0/0", dma_abort, busy); end
    endtask

    task automatic test_done_at_timeout();
        logic [3:0] g;
        set_ch(3, 6'd33, 32'h0000_3300);
        ch_req = 4'b1000;
        wait_gnt(g);
        tick();
        ch_req = 4'b0000;
        for (int i = 0; i < 7; i++) tick();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        checks++; if (ch_done !== 4'b1000 || ch_err !== 4'b0 || dma_abort !== 1'b0) begin failures++; $display("FAIL done_vs_to done=%b err=%b abort=%b exp 1000/0000/0", ch_done, ch_err, dma_abort); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        logic [3:0] g;
        int pulses;
        ch_req = 4'b0100;
        wait_gnt(g);
        tick(); tick();
        ch_req = 4'b0000;
        HRESET = 1'b1;
        tick();
        checks++; if ({ch_gnt, ch_done, ch_err, dma_start, dma_abort, busy} !== 15'b0 || {dma_len, dma_addr} !== 38'h0) begin failures++; $display("FAIL rst_wait_outs got=%b len=%0d addr=%h exp all 0", {ch_gnt, ch_done, ch_err, dma_start, dma_abort, busy}, dma_len, dma_addr); end
        HRESET = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if ({ch_done, ch_err, dma_abort} !== 9'b0) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL rst_wait_silent pulses=%0d exp=0", pulses); end
        ch_req = 4'b1000;
        wait_gnt(g);
        checks++; if (g !== 4'b1000) begin failures++; $display("FAIL rst_ch3 got=%b exp=1000", g); end
        tick();
        dma_done = 1'b1; tick(); dma_done = 1'b0;
        ch_req = 4'b1001;
        wait_gnt(g);
        checks++; if (g !== 4'b0001) begin failures++; $display("FAIL rst_ch0_prio got=%b exp=0001", g); end
        ch_req = 4'b1000;
        tick();
        dma_done = 1'b1; tick(); dma_done = 1'b0;
        ch_req = 4'b0000;
        tick(); tick(); tick();
    endtask

    initial begin
        HRESET   = 1'b1;
        ch_req   = 4'b0;
        ch_len   = '0;
        ch_addr  = '0;
        dma_done = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_req_drop();
        test_zero_len();
        test_timeout();
        test_done_at_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_ch_scheduler.md
DMA_CH_SCHEDULER -- requirements
Module: dma_ch_scheduler

Parameters
REQ-001 SHALL provide parameter NUM_CH, default 4, meaning the number of requesting channels (fixed at 4 for this release).
REQ-002 SHALL provide parameter TIMEOUT, default 1024, meaning the maximum number of WAIT cycles before a transfer is aborted.

Interface
REQ-003 SHALL have port HCLK, input, 1, meaning the single clock; all logic is rising-edge.
REQ-004 SHALL have port HRESET, input, 1, meaning reset, synchronous and active-high.
REQ-005 SHALL have port ch_req, input, 4, meaning a per-channel level request, held until ch_gnt.
REQ-006 SHALL have port ch_len, input, 4x6 (flat 24), meaning buffer length in bytes; channel n occupies bits [6n+5:6n].
REQ-007 SHALL have port ch_addr, input, 4x32 (flat 128), meaning start address; channel n occupies bits [32n+31:32n].
REQ-008 SHALL have port ch_gnt, output, 4, meaning a one-hot, one-cycle grant pulse.
REQ-009 SHALL have port ch_done, output, 4, meaning a one-hot, one-cycle completion pulse.
REQ-010 SHALL have port ch_err, output, 4, meaning a one-hot, one-cycle error pulse (zero length or timeout).
REQ-011 SHALL have port dma_start, output, 1, meaning a one-cycle start pulse to the DMA master.
REQ-012 SHALL have port dma_len, output, 6, meaning the latched length, stable from ISSUE through WAIT.
REQ-013 SHALL have port dma_addr, output, 32, meaning the latched {ADDR_HIGH, ADDR_LOW}, stable from ISSUE through WAIT.
REQ-014 SHALL have port dma_abort, output, 1, meaning a one-cycle abort pulse on timeout.
REQ-015 SHALL have port dma_done, input, 1, meaning the DMA master has returned to Idle after its final data phase.
REQ-016 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ARB, ISSUE, WAIT.
REQ-018 IDLE SHALL move to ARB on the cycle after any ch_req bit is seen high, and SHALL otherwise stay in IDLE.
REQ-019 ARB (1 cycle) SHALL pick a channel round-robin, searching from (last_gnt+1) mod 4 upward with wrap.
REQ-020 ARB SHALL pulse ch_gnt for the winner and latch its len/addr into dma_len/dma_addr.
REQ-021 If every ch_req bit has dropped by ARB, ARB SHALL return to IDLE with no grant.
REQ-022 A winner with len==0 SHALL receive ch_gnt and ch_err in the same ARB cycle, SHALL update last_gnt, SHALL go to IDLE, and SHALL NOT assert dma_start.
REQ-023 ISSUE SHALL assert dma_start for exactly 1 cycle, SHALL clear the timeout counter, and SHALL then enter WAIT.
REQ-024 In WAIT, dma_done=1 SHALL pulse ch_done[winner] on the following cycle and return to IDLE.
REQ-025 In WAIT, the 16-bit timeout counter SHALL increment each cycle; on reaching TIMEOUT-1 without dma_done, the block SHALL pulse dma_abort and ch_err[winner] and return to IDLE.
REQ-026 If dma_done and the timeout occur in the same cycle, done SHALL win: ch_done is pulsed and ch_err/dma_abort are not.
REQ-027 dma_done seen outside WAIT SHALL be ignored.
REQ-028 last_gnt SHALL update in ARB only, so the same channel cannot win twice in a row while another channel requests.
REQ-029 Requests arriving during ISSUE/WAIT SHALL wait for the next ARB; no request is dropped while its ch_req stays high.
REQ-030 Minimum request-to-start latency SHALL be 3 cycles (IDLE sample, ARB, ISSUE).
REQ-031 At most one ch_gnt, ch_done and ch_err bit SHALL be high in any cycle.

Reset
REQ-032 While HRESET=1 at a rising edge, the FSM SHALL go to IDLE, last_gnt to 3 (so channel 0 has first priority), and the timeout counter to 0.
REQ-033 While HRESET=1, all outputs SHALL be 0: ch_gnt, ch_done, ch_err, dma_start, dma_abort, busy, dma_len=0, dma_addr=0.
REQ-034 Reset during WAIT SHALL abandon the transfer silently, with no ch_done, ch_err or dma_abort pulse.

Verification
REQ-035 Bench SHALL cover: ch_req=0001, len=16, addr=0x0000_0100 -> ch_gnt=0001 then dma_start 1 cycle later with dma_len=16, dma_addr=0x100; dma_done -> ch_done=0001.
REQ-036 Bench SHALL cover: ch_req=1111 held through four transfers after reset -> grant order 0,1,2,3; a fifth request on ch0 -> ch0 granted.
REQ-037 Bench SHALL cover: ch_req=0100, len=0 -> ch_gnt=0100 and ch_err=0100 in the same cycle, no dma_start, back in IDLE next cycle.
REQ-038 Bench SHALL cover: TIMEOUT=8, no dma_done -> dma_abort and ch_err pulse 8 cycles after entering WAIT.
REQ-039 Bench SHALL cover: dma_done coincident with the timeout cycle -> ch_done only.
REQ-040 Bench SHALL cover: HRESET asserted mid-WAIT -> all outputs 0 next cycle, no pulses; after release, ch_req=1000 is granted and ch0 keeps first priority.
